// File: rtl/uart_sched_pkg.sv
// Shared types and widths for the UART transmit scheduler.
// SCHED_TIMEOUT_EN (in uart_tx_scheduler) enables the frame timeout.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        WAIT,
        REARM
    } state_t;

    localparam int DATA_W    = 7;
    localparam int TIMEOUT_W = 16;

endpackage

// File: rtl/uart_tx_scheduler_arb.sv
// Round-robin winner search starting just above the last-served index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [ID_W-1:0]  winner_o,
    output logic             any_o
);

    logic found;
    int   idx;

    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(ptr_i) + i) % N_REQ;
            if (!found && req_i[idx]) begin
                found    = 1'b1;
                winner_o = ID_W'(idx);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter among N_REQ clients.
// Define SCHED_TIMEOUT_EN to abort frames stuck in START/WAIT.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 4096,
    parameter int ID_W        = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [DATA_W*N_REQ-1:0] data_in,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        done,
    output logic [ID_W-1:0]         cur_id,
    output logic                    sched_busy,
    output logic                    err,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_busy,
    output logic                    tx_resetN
);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     cur_q, cur_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic                err_q, err_d;
    logic [ID_W-1:0]     winner;
    logic                any_req;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .any_o    (any_req)
    );

`ifdef SCHED_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYC;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        data_d  = data_q;
        ack_d   = '0;
        done_d  = '0;
        err_d   = 1'b0;
`ifdef SCHED_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_req) state_d = GRANT;
            end
            GRANT: begin
                if (any_req) begin
                    data_d        = data_in[int'(winner)*DATA_W +: DATA_W];
                    cur_d         = winner;
                    ptr_d         = winner;
                    ack_d[winner] = 1'b1;
                    state_d       = START;
`ifdef SCHED_TIMEOUT_EN
                    cnt_d         = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (tx_busy) state_d = WAIT;
            end
            WAIT: begin
                if (!tx_busy) begin
                    state_d       = REARM;
                    done_d[cur_q] = 1'b1;
                end
            end
            REARM: state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef SCHED_TIMEOUT_EN
        // Timeout wins over a same-cycle completion: the frame is dropped.
        if (state_q == START || state_q == WAIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == TIMEOUT_W'(TIMEOUT_CYC - 1)) begin
                state_d = REARM;
                done_d  = '0;
                err_d   = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(N_REQ - 1);
            cur_q   <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef SCHED_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign ack        = ack_q;
    assign done       = done_q;
    assign cur_id     = cur_q;
    assign tx_data    = data_q;
    assign sched_busy = (state_q != IDLE);
    assign tx_start   = (state_q == START);
    assign tx_resetN  = ~(reset | (state_q == REARM));
`ifdef SCHED_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: frame table plus corner sequences.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [27:0] data_in;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic [1:0]  cur_id;
    logic        sched_busy;
    logic        err;
    logic        tx_start;
    logic [6:0]  tx_data;
    logic        tx_busy;
    logic        tx_resetN;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .N_REQ       (4),
        .TIMEOUT_CYC (16),
        .ID_W        (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .data_in    (data_in),
        .ack        (ack),
        .done       (done),
        .cur_id     (cur_id),
        .sched_busy (sched_busy),
        .err        (err),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .tx_resetN  (tx_resetN)
    );

    typedef struct {
        logic [3:0] r;
        int         w;
        logic [6:0] ch;
        int         d;
        int         len;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic [27:0] lanes(input int w, input logic [6:0] ch);
        logic [27:0] di;
        for (int i = 0; i < 4; i++)
            di[7*i +: 7] = (i == w) ? ch : ~ch;
        return di;
    endfunction

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == 4'b0 && n < 20);
    endtask

    task automatic frame(input vec_t v);
        int         n;
        logic [3:0] one;
        one = 4'b0001 << v.w;
        @(posedge clk); #1;
        req     = v.r;
        data_in = lanes(v.w, v.ch);
        wait_ack(n);
        chk("ack_latency", n - 1, 2);
        chk("ack_vec", {28'b0, ack}, {28'b0, one});
        chk("cur_id", {30'b0, cur_id}, v.w);
        chk("tx_data", {25'b0, tx_data}, {25'b0, v.ch});
        chk("tx_start", {31'b0, tx_start}, 1);
        @(posedge clk); #1;
        req     = 4'b0;
        data_in = ~data_in;
        @(negedge clk);
        chk("ack_single", {28'b0, ack}, 0);
        repeat (v.d) @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (v.len) @(posedge clk);
        #1 tx_busy = 1'b0;
        chk("tx_data_hold", {25'b0, tx_data}, {25'b0, v.ch});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == 4'b0 && n < 20);
        chk("done_vec", {28'b0, done}, {28'b0, one});
        chk("rearm_low", {31'b0, tx_resetN}, 0);
        chk("err_idle", {31'b0, err}, 0);
        @(negedge clk);
        chk("rearm_1cyc", {31'b0, tx_resetN}, 1);
        chk("done_single", {28'b0, done}, 0);
        chk("idle_after", {31'b0, sched_busy}, 0);
    endtask

    initial begin
        int n;
        tbl[0] = '{4'b1111, 0, 7'h10, 1, 2};
        tbl[1] = '{4'b1111, 1, 7'h11, 2, 3};
        tbl[2] = '{4'b1111, 2, 7'h12, 1, 1};
        tbl[3] = '{4'b1111, 3, 7'h13, 4, 5};
        tbl[4] = '{4'b1111, 0, 7'h14, 1, 2};
        tbl[5] = '{4'b0100, 2, 7'h41, 3, 10};
        tbl[6] = '{4'b0010, 1, 7'h22, 2, 2};
        tbl[7] = '{4'b1010, 3, 7'h33, 1, 4};
        tbl[8] = '{4'b0010, 1, 7'h55, 2, 3};

        reset   = 1'b1;
        req     = 4'b0;
        data_in = '0;
        tx_busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resetN", {31'b0, tx_resetN}, 0);
        chk("rst_ack", {28'b0, ack}, 0);
        chk("rst_done", {28'b0, done}, 0);
        chk("rst_busy", {31'b0, sched_busy}, 0);
        chk("rst_cur", {30'b0, cur_id}, 0);
        chk("rst_data", {25'b0, tx_data}, 0);
        chk("rst_start", {31'b0, tx_start}, 0);
        chk("rst_err", {31'b0, err}, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rel_resetN", {31'b0, tx_resetN}, 1);

        for (int i = 0; i < 9; i++) frame(tbl[i]);

        // One-cycle request pulse: GRANT finds nothing and returns to IDLE.
        @(posedge clk); #1 req = 4'b0001;
        @(posedge clk); #1 req = 4'b0000;
        @(negedge clk);
        chk("pulse_grant", {31'b0, sched_busy}, 1);
        @(negedge clk);
        chk("pulse_idle", {31'b0, sched_busy}, 0);
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack != 4'b0) n++;
        end
        chk("pulse_no_ack", n, 0);

        // Reset while in WAIT: frame lost, pointer back to N_REQ-1.
        @(posedge clk); #1;
        req     = 4'b0001;
        data_in = lanes(0, 7'h2a);
        wait_ack(n);
        chk("mid_ack", {28'b0, ack}, 1);
        @(posedge clk); #1;
        req     = 4'b0;
        tx_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("mid_resetN", {31'b0, tx_resetN}, 0);
        @(posedge clk); #1;
        reset   = 1'b0;
        tx_busy = 1'b0;
        @(negedge clk);
        chk("mid_idle", {31'b0, sched_busy}, 0);
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (done != 4'b0) n++;
        end
        chk("mid_no_done", n, 0);
        frame('{4'b1111, 0, 7'h5a, 1, 2});

`ifdef SCHED_TIMEOUT_EN
        @(posedge clk); #1;
        req     = 4'b0100;
        data_in = lanes(2, 7'h3c);
        wait_ack(n);
        chk("tmo_ack", {28'b0, ack}, 4'b0100);
        tx_busy = 1'b1;
        @(posedge clk); #1 req = 4'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (err == 1'b0 && n < 40);
        chk("tmo_cycles", n, 16);
        chk("tmo_rearm", {31'b0, tx_resetN}, 0);
        chk("tmo_no_done", {28'b0, done}, 0);
        chk("tmo_start", {31'b0, tx_start}, 0);
        @(negedge clk);
        chk("tmo_err_1cyc", {31'b0, err}, 0);
        #1 tx_busy = 1'b0;
        frame('{4'b0001, 0, 7'h66, 1, 2});
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
